mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL provide port: clock  input  1  single system clock, all state changes on rising edge.
REQ-002 SHALL provide port: reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL provide ports: opcode  input  6  instruction[31:26]; funct  input  6  instruction[5:0]; zero_flag  input  1  ALU zero result.
REQ-004 SHALL provide port: mem_ready  input  1  memory handshake, high when the current read/write completes this cycle.
REQ-005 SHALL provide 1-bit outputs: pc_write, pc_write_cond, i_or_d (0=PC, 1=ALU out), ir_write, mem_read, mem_write, mem_to_reg (1=memory data), reg_dst (0=rt, 1=rd), reg_write.
REQ-006 SHALL provide outputs: alu_src_a  2 (00=PC, 01=reg A, 10=shamt); alu_src_b  2 (00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2); alu_op  4; pc_source  2 (00=ALU, 01=ALU out reg, 10=jump target).
REQ-007 SHALL provide outputs: state  4  current state code; instr_done  1  one-cycle retire pulse; illegal_op  1  one-cycle pulse; retired_count  16  retired-instruction counter.

Function
REQ-008 SHALL encode states: INIT=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12, ILLEGAL=13; codes 14-15 SHALL transition to INIT.
REQ-009 SHALL encode alu_op: 0000 add, 0001 sub, 0010 and, 0011 or, 0101 lui (imm<<16), 1111 funct-decoded R-type.
REQ-010 SHALL decode outputs from the state register and mem_ready only (Moore except handshake-qualified strobes); every output not listed for a state SHALL be 0.
REQ-011 INIT: all outputs 0; next state FETCH unconditionally.
REQ-012 FETCH: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=add, pc_source=00; ir_write=pc_write=mem_ready; SHALL remain in FETCH while mem_ready=0, go to DECODE when 1.
REQ-013 DECODE: alu_src_a=00, alu_src_b=11, alu_op=add; next by opcode: 000000->R_EXEC, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, 001000/001100/001101/001111->I_EXEC, any other->ILLEGAL.
REQ-014 MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=add; next MEM_READ for 100011, MEM_WRITE for 101011.
REQ-015 MEM_READ: mem_read=1, i_or_d=1; wait on mem_ready, then MEM_WB.
REQ-016 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-017 MEM_WRITE: mem_write=1, i_or_d=1; wait on mem_ready, then FETCH.
REQ-018 R_EXEC: alu_src_a=10 when funct in {000000,000010,000011} (shifts) else 01, alu_src_b=00, alu_op=1111; next R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-019 I_EXEC: alu_src_a=01, alu_src_b=10, alu_op=add/and/or/lui for 001000/001100/001101/001111; next I_WB. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-020 BRANCH: alu_src_a=01, alu_src_b=00, alu_op=sub, pc_write_cond=1, pc_source=01; next FETCH. JUMP: pc_write=1, pc_source=10; next FETCH.
REQ-021 ILLEGAL: illegal_op=1 for that single cycle, no register/memory/PC write; next FETCH; retired_count unchanged.
REQ-022 instr_done SHALL pulse on the last cycle of each instruction (MEM_WB, MEM_WRITE with mem_ready=1, R_WB, I_WB, BRANCH, JUMP); retired_count SHALL increment by 1 on that edge, wrapping 0xFFFF->0x0000.
REQ-023 opcode/funct SHALL be sampled only in DECODE, MEM_ADDR, R_EXEC, I_EXEC; changes elsewhere SHALL have no effect.
REQ-024 mem_ready outside FETCH/MEM_READ/MEM_WRITE SHALL be ignored; mem_write and mem_read SHALL never be 1 simultaneously.

Reset
REQ-025 reset_n=0 SHALL immediately (no clock) force state=INIT, retired_count=0, all outputs 0, including mid-wait in FETCH/MEM_READ/MEM_WRITE.
REQ-026 After reset_n deasserts, first rising edge SHALL enter FETCH; no write strobe SHALL assert before FETCH with mem_ready=1.

Verification
REQ-027 Reset then add (opcode 000000, funct 100000), mem_ready=1 always -> states 0,1,2,7,8,1; reg_write=1, reg_dst=1 in R_WB; retired_count=1.
REQ-028 lw (100011) with mem_ready low 3 cycles in MEM_READ -> state holds 4 for 3 cycles, mem_read/i_or_d steady 1, then MEM_WB with mem_to_reg=1; 5 cycles nominal +3.
REQ-029 beq (000100) -> BRANCH with pc_write_cond=1, alu_op=0001, pc_source=01, instr_done=1; j (000010) -> pc_write=1, pc_source=10.
REQ-030 opcode 111111 -> DECODE->ILLEGAL, illegal_op pulse 1 cycle, no write strobes, retired_count unchanged, then FETCH.
REQ-031 reset_n low asynchronously during MEM_WRITE wait -> mem_write drops to 0 before next edge, state=0, retired_count=0.
REQ-032 Retire 65536 sw instructions -> retired_count wraps to 0x0000, instr_done pulses 65536 times.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if
//   Groups the controller's decode inputs, memory handshake and datapath
//   control outputs into one bundle.
//   master : the controller (drives the control strobes and status).
//   slave  : the datapath / memory side (drives opcode, funct, flags, mem_ready).
//   Signals:
//     opcode[5:0], funct[5:0], zero_flag, mem_ready     datapath -> controller
//     pc_write, pc_write_cond, i_or_d, ir_write,
//     mem_read, mem_write, mem_to_reg, reg_dst,
//     reg_write, alu_src_a[1:0], alu_src_b[1:0],
//     alu_op[3:0], pc_source[1:0]                       controller -> datapath
//     state[3:0], instr_done, illegal_op,
//     retired_count[15:0]                               controller status
interface mips_multicycle_ctrl_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero_flag;
    logic        mem_ready;

    logic        pc_write;
    logic        pc_write_cond;
    logic        i_or_d;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic [1:0]  pc_source;

    logic [3:0]  state;
    logic        instr_done;
    logic        illegal_op;
    logic [15:0] retired_count;

    modport master (
        input  opcode, funct, zero_flag, mem_ready,
        output pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, illegal_op, retired_count
    );

    modport slave (
        output opcode, funct, zero_flag, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, illegal_op, retired_count
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Multicycle MIPS main control unit. A 4-bit state register walks each
//   instruction through fetch / decode / execute / memory / write-back.
//   Control outputs are decoded from the state register; only the fetch
//   strobes (ir_write, pc_write) and the store retire pulse are qualified
//   by mem_ready. opcode/funct are consulted only in DECODE, MEM_ADDR,
//   R_EXEC and I_EXEC, where the instruction register is stable.
//   Ports:
//     clock    rising-edge system clock
//     reset_n  asynchronous active-low reset (state=INIT, count=0, outputs 0)
//     bus      mips_multicycle_ctrl_if.master: decode inputs, handshake,
//              datapath strobes, state, instr_done, illegal_op, retired_count
//   zero_flag is part of the bundle for the datapath; the branch decision
//   itself is pc_write_cond AND zero_flag, formed outside this block.
module mips_multicycle_ctrl (
    input  logic                   clock,
    input  logic                   reset_n,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_INIT      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_I_EXEC    = 4'd11,
        S_I_WB      = 4'd12,
        S_ILLEGAL   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_LUI  = 4'b0101;
    localparam logic [3:0] ALU_FUNC = 4'b1111;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic        retire;

    // Next-state logic.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            S_INIT:      state_d = S_FETCH;
            S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                          state_d = S_R_EXEC;
                    OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
                    OP_BEQ:                            state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  state_d = S_I_EXEC;
                    default:                           state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                // Anything but lw/sw here means the IR changed under us;
                // treat it as illegal rather than risk a stray store.
                if (bus.opcode == OP_LW)      state_d = S_MEM_READ;
                else if (bus.opcode == OP_SW) state_d = S_MEM_WRITE;
                else                          state_d = S_ILLEGAL;
            end
            S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_ILLEGAL:
                         state_d = S_FETCH;
            default:     state_d = S_INIT;  // unused codes 14/15 recover
        endcase
    end

    // Output decode: state register plus mem_ready for the handshake strobes.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 2'b00;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = ALU_ADD;
        bus.pc_source     = 2'b00;
        bus.illegal_op    = 1'b0;
        retire            = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: bus.alu_src_b = 2'b11;  // precompute branch target
            S_MEM_ADDR: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                retire         = 1'b1;
            end
            S_MEM_WRITE: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                retire        = bus.mem_ready;
            end
            S_R_EXEC: begin
                // sll/srl/sra take their first operand from shamt.
                bus.alu_src_a = (bus.funct == 6'b000000 || bus.funct == 6'b000010 ||
                                 bus.funct == 6'b000011) ? 2'b10 : 2'b01;
                bus.alu_op    = ALU_FUNC;
            end
            S_R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                retire        = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 2'b01;
                bus.alu_op        = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
                retire            = 1'b1;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
                retire        = 1'b1;
            end
            S_I_EXEC: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                case (bus.opcode)
                    OP_ANDI: bus.alu_op = ALU_AND;
                    OP_ORI:  bus.alu_op = ALU_OR;
                    OP_LUI:  bus.alu_op = ALU_LUI;
                    default: bus.alu_op = ALU_ADD;
                endcase
            end
            S_I_WB: begin
                bus.reg_write = 1'b1;
                retire        = 1'b1;
            end
            S_ILLEGAL: bus.illegal_op = 1'b1;
            default: ;
        endcase
    end

    // Retired-instruction counter wraps naturally at 16 bits.
    always_comb begin
        count_d = retire ? count_q + 16'd1 : count_q;
    end

    // NOTE: sequential state uses non-blocking assignments; the async reset clears state without a clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign bus.state         = state_q;
    assign bus.instr_done    = retire;
    assign bus.retired_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Directed bench for mips_multicycle_ctrl. Each step pushes the expected
//   state, control word and retired count for the coming cycle onto a
//   scoreboard; the entry is popped and compared on the falling edge.
//   Expected control words come from a per-state table of the documented
//   output values; expected states come from the directed sequence.
module tb_mips_multicycle_ctrl;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } outs_t;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        outs_t       o;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          done_seen   = 0;
    logic [15:0] exp_cnt     = 16'd0;

    // Documented control word for each state.
    function automatic outs_t spec_out(input logic [3:0] st, input logic mr,
                                       input logic [5:0] opc, input logic [5:0] fn);
        outs_t o;
        o = '0;
        case (st)
            4'd1:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
            4'd2:  o.alu_src_b = 2'b11;
            4'd3:  begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; end
            4'd4:  begin o.mem_read = 1; o.i_or_d = 1; end
            4'd5:  begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
            4'd6:  begin o.mem_write = 1; o.i_or_d = 1; o.instr_done = mr; end
            4'd7:  begin
                       o.alu_src_a = (fn == 6'd0 || fn == 6'd2 || fn == 6'd3) ? 2'b10 : 2'b01;
                       o.alu_op    = 4'b1111;
                   end
            4'd8:  begin o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; end
            4'd9:  begin
                       o.alu_src_a = 2'b01; o.alu_op = 4'b0001; o.pc_write_cond = 1;
                       o.pc_source = 2'b01; o.instr_done = 1;
                   end
            4'd10: begin o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1; end
            4'd11: begin
                       o.alu_src_a = 2'b01; o.alu_src_b = 2'b10;
                       if (opc == 6'b001100)      o.alu_op = 4'b0010;
                       else if (opc == 6'b001101) o.alu_op = 4'b0011;
                       else if (opc == 6'b001111) o.alu_op = 4'b0101;
                       else                       o.alu_op = 4'b0000;
                   end
            4'd12: begin o.reg_write = 1; o.instr_done = 1; end
            4'd13: o.illegal_op = 1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic outs_t observed();
        outs_t o;
        o.pc_write      = bus.pc_write;
        o.pc_write_cond = bus.pc_write_cond;
        o.i_or_d        = bus.i_or_d;
        o.ir_write      = bus.ir_write;
        o.mem_read      = bus.mem_read;
        o.mem_write     = bus.mem_write;
        o.mem_to_reg    = bus.mem_to_reg;
        o.reg_dst       = bus.reg_dst;
        o.reg_write     = bus.reg_write;
        o.alu_src_a     = bus.alu_src_a;
        o.alu_src_b     = bus.alu_src_b;
        o.alu_op        = bus.alu_op;
        o.pc_source     = bus.pc_source;
        o.instr_done    = bus.instr_done;
        o.illegal_op    = bus.illegal_op;
        return o;
    endfunction

    task automatic push_exp(input string tag, input logic [3:0] st);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.o   = spec_out(st, bus.mem_ready, bus.opcode, bus.funct);
        e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t  e;
        outs_t got;
        e   = sb.pop_front();
        got = observed();
        vectors++;
        if (bus.instr_done === 1'b1) done_seen++;
        if (e.o.instr_done) exp_cnt = exp_cnt + 16'd1;
        assert (bus.state === e.st && got === e.o && bus.retired_count === e.cnt) else begin
            miscompares++;
            $error("FAIL %s: got state=%0d ctrl=%h count=%h, expected state=%0d ctrl=%h count=%h",
                   e.tag, bus.state, got, bus.retired_count, e.st, e.o, e.cnt);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // One clock cycle: expectation queued now, compared at the falling edge,
    // then the bench advances to just after the next rising edge.
    task automatic step(input string tag, input logic [3:0] st);
        push_exp(tag, st);
        @(negedge clock);
        compare();
        @(posedge clock);
        #1;
    endtask

    // Assert reset between edges and check the effect without any clock.
    task automatic async_reset_check(input string tag);
        reset_n = 1'b0;
        exp_cnt = 16'd0;
        push_exp(tag, 4'd0);
        #1;
        compare();
    endtask

    task automatic fetch_decode(input string name, input logic [5:0] opc, input logic [5:0] fn);
        bus.opcode    = opc;
        bus.funct     = fn;
        bus.mem_ready = 1'b1;
        step({name, "_fetch"}, 4'd1);
        step({name, "_decode"}, 4'd2);
    endtask

    logic [5:0] i_ops [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001111};

    initial begin
        bus.opcode    = 6'd0;
        bus.funct     = 6'd0;
        bus.zero_flag = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset takes effect with no clock edge, and holds across edges.
        #2;
        async_reset_check("reset_async");
        @(posedge clock);
        #1;
        step("reset_hold", 4'd0);
        reset_n = 1'b1;

        // First cycle after release is INIT; fetch waits with no write strobes.
        step("init", 4'd0);
        step("fetch_wait0", 4'd1);
        step("fetch_wait1", 4'd1);

        // add: 0,1,2,7,8 then FETCH; opcode noise in R_WB is ignored.
        fetch_decode("add", 6'b000000, 6'b100000);
        step("add_rexec", 4'd7);
        bus.opcode = 6'b111111;
        bus.funct  = 6'b111111;
        step("add_rwb", 4'd8);

        // sll selects shamt as ALU operand A.
        fetch_decode("sll", 6'b000000, 6'b000000);
        step("sll_rexec", 4'd7);
        step("sll_rwb", 4'd8);

        // lw with memory stalled three cycles; opcode garbage while waiting.
        fetch_decode("lw", 6'b100011, 6'd0);
        step("lw_addr", 4'd3);
        bus.mem_ready = 1'b0;
        bus.opcode    = 6'b000010;
        for (int i = 0; i < 3; i++) step("lw_wait", 4'd4);
        bus.mem_ready = 1'b1;
        step("lw_read_done", 4'd4);
        step("lw_wb", 4'd5);

        // sw with one stall cycle.
        fetch_decode("sw", 6'b101011, 6'd0);
        step("sw_addr", 4'd3);
        bus.mem_ready = 1'b0;
        step("sw_wait", 4'd6);
        bus.mem_ready = 1'b1;
        step("sw_done", 4'd6);

        // beq and j.
        bus.zero_flag = 1'b1;
        fetch_decode("beq", 6'b000100, 6'd0);
        step("beq_branch", 4'd9);
        bus.zero_flag = 1'b0;
        fetch_decode("j", 6'b000010, 6'd0);
        step("j_jump", 4'd10);

        // I-type: addi, andi, ori, lui.
        for (int i = 0; i < 4; i++) begin
            fetch_decode("itype", i_ops[i], 6'd0);
            step("itype_exec", 4'd11);
            step("itype_wb", 4'd12);
        end

        // Illegal opcodes: single illegal_op pulse, no retire.
        fetch_decode("ill", 6'b111111, 6'd0);
        step("ill_pulse", 4'd13);
        fetch_decode("ill2", 6'b000011, 6'd0);
        step("ill2_pulse", 4'd13);
        bus.opcode = 6'b000010;
        step("after_ill_fetch", 4'd1);
        step("after_ill_decode", 4'd2);
        step("after_ill_jump", 4'd10);

        // Counter wrap: preload near the top and retire three jumps.
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        exp_cnt   = 16'hFFFE;
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            fetch_decode("wrap", 6'b000010, 6'd0);
            step("wrap_jump", 4'd10);
        end
        chk_int("wrap_pulses", done_seen, 3);
        chk_int("wrap_count", int'(bus.retired_count), 1);

        // Async reset while a store waits on memory.
        fetch_decode("sw_rst", 6'b101011, 6'd0);
        step("sw_rst_addr", 4'd3);
        bus.mem_ready = 1'b0;
        step("sw_rst_wait", 4'd6);
        #2;
        async_reset_check("reset_in_mem_write");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step("post_rst_init", 4'd0);
        step("post_rst_fetch_wait", 4'd1);
        fetch_decode("post_rst_j", 6'b000010, 6'd0);
        step("post_rst_jump", 4'd10);

        chk_int("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
